// File: rtl/operand_loader.sv
// Operand loader: streams packed operand words into the weight buffer and then
// the input buffer, then runs the start/done handshake with the matmul controller.
//
// state     | meaning
// IDLE      | waiting for go_i; checks the requested lengths
// LOAD_W    | accepting stream words into the weight buffer
// LOAD_I    | accepting stream words into the input buffer
// START     | start_o high; waiting for the controller to clear done_i
// WAIT_DONE | start_o high; waiting for done_i to rise
module operand_loader #(
  parameter int WIDTH  = 8,
  parameter int COL    = 4,
  parameter int W_SIZE = 256,
  parameter int I_SIZE = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        go_i,
  input  logic [$clog2(W_SIZE):0]     cfg_w_len_i,
  input  logic [$clog2(I_SIZE):0]     cfg_i_len_i,
  input  logic                        s_valid_i,
  input  logic [WIDTH*COL-1:0]        s_data_i,
  output logic                        s_ready_o,
  output logic                        wb_mem_cenb_o,
  output logic                        wb_mem_wenb_o,
  output logic [$clog2(W_SIZE)-1:0]   wb_mem_addr_o,
  output logic [WIDTH*COL-1:0]        wb_mem_data_o,
  output logic                        ib_mem_cenb_o,
  output logic                        ib_mem_wenb_o,
  output logic [$clog2(I_SIZE)-1:0]   ib_mem_addr_o,
  output logic [WIDTH*COL-1:0]        ib_mem_data_o,
  output logic                        start_o,
  input  logic                        done_i,
  output logic                        load_active_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int DW  = WIDTH * COL;
  localparam int WAW = $clog2(W_SIZE);
  localparam int IAW = $clog2(I_SIZE);
  localparam int CW  = (WAW > IAW) ? WAW : IAW;
  localparam int LW  = CW + 1;
  localparam logic [WAW:0] W_MAX = (WAW + 1)'(W_SIZE);
  localparam logic [IAW:0] I_MAX = (IAW + 1)'(I_SIZE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    LOAD_I    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [LW-1:0]   w_len, w_len_nx;
  logic [LW-1:0]   i_len, i_len_nx;
  logic            wb_wr, wb_wr_nx;
  logic            ib_wr, ib_wr_nx;
  logic            err, err_nx;
  logic [WAW-1:0]  wb_addr;
  logic [IAW-1:0]  ib_addr;
  logic [DW-1:0]   wb_data, ib_data;
  logic            cfg_ok;
  logic            w_last, i_last;

  assign cfg_ok = (cfg_w_len_i != '0) && (cfg_w_len_i <= W_MAX) &&
                  (cfg_i_len_i != '0) && (cfg_i_len_i <= I_MAX);

  // The counter is compared one bit wider so a full-depth length still matches.
  assign w_last = ({1'b0, cnt} == (w_len - LW'(1)));
  assign i_last = ({1'b0, cnt} == (i_len - LW'(1)));

  // Next-state, counter and registered-write decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    w_len_nx = w_len;
    i_len_nx = i_len;
    wb_wr_nx = 1'b0;
    ib_wr_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (go_i) begin
          if (cfg_ok) begin
            w_len_nx = LW'(cfg_w_len_i);
            i_len_nx = LW'(cfg_i_len_i);
            cnt_nx   = '0;
            state_nx = LOAD_W;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (s_valid_i) begin
          wb_wr_nx = 1'b1;
          if (w_last) begin
            cnt_nx   = '0;
            state_nx = LOAD_I;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      LOAD_I: begin
        if (s_valid_i) begin
          ib_wr_nx = 1'b1;
          if (i_last) begin
            cnt_nx   = '0;
            state_nx = START;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      START: begin
        // A done_i left high by the previous run is ignored until it drops.
        if (!done_i) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter, lengths and registered buffer write ports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      w_len   <= '0;
      i_len   <= '0;
      wb_wr   <= 1'b0;
      ib_wr   <= 1'b0;
      wb_addr <= '0;
      ib_addr <= '0;
      wb_data <= '0;
      ib_data <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      w_len   <= w_len_nx;
      i_len   <= i_len_nx;
      wb_wr   <= wb_wr_nx;
      ib_wr   <= ib_wr_nx;
      wb_addr <= wb_wr_nx ? cnt[WAW-1:0] : '0;
      ib_addr <= ib_wr_nx ? cnt[IAW-1:0] : '0;
      wb_data <= wb_wr_nx ? s_data_i : '0;
      ib_data <= ib_wr_nx ? s_data_i : '0;
      err     <= err_nx;
    end
  end

  assign s_ready_o     = (state == LOAD_W) || (state == LOAD_I);
  assign wb_mem_cenb_o = ~wb_wr;
  assign wb_mem_wenb_o = ~wb_wr;
  assign wb_mem_addr_o = wb_addr;
  assign wb_mem_data_o = wb_data;
  assign ib_mem_cenb_o = ~ib_wr;
  assign ib_mem_wenb_o = ~ib_wr;
  assign ib_mem_addr_o = ib_addr;
  assign ib_mem_data_o = ib_data;
  assign start_o       = (state == START) || (state == WAIT_DONE);
  assign busy_o        = (state != IDLE);
  assign err_o         = err;
  // Stays up through the cycle carrying the final registered write.
  assign load_active_o = s_ready_o || wb_wr || ib_wr;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: randomized stream traffic against a
// word-count based reference model, plus directed scenarios with literal checks.
module tb_operand_loader;
  localparam int WIDTH  = 8;
  localparam int COL    = 4;
  localparam int W_SIZE = 256;
  localparam int I_SIZE = 256;
  localparam int DW     = WIDTH * COL;
  localparam int WAW    = $clog2(W_SIZE);
  localparam int IAW    = $clog2(I_SIZE);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           go = 1'b0;
  logic [WAW:0]   cfg_w = '0;
  logic [IAW:0]   cfg_i = '0;
  logic           s_valid = 1'b0;
  logic [DW-1:0]  s_data = '0;
  logic           done = 1'b0;
  logic           s_ready, wb_cenb, wb_wenb, ib_cenb, ib_wenb;
  logic [WAW-1:0] wb_addr;
  logic [IAW-1:0] ib_addr;
  logic [DW-1:0]  wb_data, ib_data;
  logic           start, load_active, busy, err;

  always #5 clk = ~clk;

  operand_loader #(.WIDTH(WIDTH), .COL(COL), .W_SIZE(W_SIZE), .I_SIZE(I_SIZE)) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .cfg_w_len_i(cfg_w), .cfg_i_len_i(cfg_i),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .wb_mem_cenb_o(wb_cenb), .wb_mem_wenb_o(wb_wenb), .wb_mem_addr_o(wb_addr),
    .wb_mem_data_o(wb_data),
    .ib_mem_cenb_o(ib_cenb), .ib_mem_wenb_o(ib_wenb), .ib_mem_addr_o(ib_addr),
    .ib_mem_data_o(ib_data),
    .start_o(start), .done_i(done), .load_active_o(load_active), .busy_o(busy),
    .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is "accepting words" until wlen+ilen words are taken;
  // the k-th accepted word lands in the weight buffer at k or input buffer at k-wlen.
  int            m_phase = 0; // 0 idle, 1 accepting, 2 awaiting done low, 3 awaiting done high
  int            m_acc = 0, m_wlen = 0, m_ilen = 0;
  bit            model_on = 1'b0;
  bit            e_ready, e_start, e_busy, e_err, e_wr_w, e_wr_i, e_lact;
  int            e_addr;
  logic [DW-1:0] e_data;

  always @(posedge clk) begin : model
    bit hs;
    int cw, ci;
    hs = s_valid && e_ready;
    cw = int'(cfg_w);
    ci = int'(cfg_i);
    if (rst) begin
      m_phase = 0; m_acc = 0; model_on = 1'b1;
      e_ready = 0; e_start = 0; e_busy = 0; e_err = 0; e_wr_w = 0; e_wr_i = 0;
      e_lact = 0; e_addr = 0; e_data = '0;
    end else begin
      e_err = 0; e_wr_w = 0; e_wr_i = 0; e_addr = 0; e_data = '0;
      case (m_phase)
        0: if (go) begin
             if (cw >= 1 && cw <= W_SIZE && ci >= 1 && ci <= I_SIZE) begin
               m_phase = 1; m_acc = 0; m_wlen = cw; m_ilen = ci;
             end else e_err = 1;
           end
        1: if (hs) begin
             if (m_acc < m_wlen) begin e_wr_w = 1; e_addr = m_acc; end
             else begin e_wr_i = 1; e_addr = m_acc - m_wlen; end
             e_data = s_data;
             m_acc++;
             if (m_acc == m_wlen + m_ilen) m_phase = 2;
           end
        2: if (!done) m_phase = 3;
        default: if (done) m_phase = 0;
      endcase
      e_ready = (m_phase == 1);
      e_start = (m_phase >= 2);
      e_busy  = (m_phase != 0);
      e_lact  = e_ready || e_wr_w || e_wr_i;
    end
  end

  // Captured buffer contents and counters, used by the literal checks.
  logic [DW-1:0] wmem [W_SIZE];
  logic [DW-1:0] imem [I_SIZE];
  int wr_cnt = 0, err_seen = 0, last_waddr = -1;

  // Per-cycle comparison of every output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("s_ready", s_ready, e_ready);
      chk("start", start, e_start);
      chk("busy", busy, e_busy);
      chk("err", err, e_err);
      chk("load_active", load_active, e_lact);
      chk("wb_cenb", wb_cenb, !e_wr_w);
      chk("wb_wenb", wb_wenb, !e_wr_w);
      chk("wb_addr", 64'(wb_addr), 64'(e_wr_w ? e_addr : 0));
      chk("wb_data", wb_data, e_wr_w ? e_data : '0);
      chk("ib_cenb", ib_cenb, !e_wr_i);
      chk("ib_wenb", ib_wenb, !e_wr_i);
      chk("ib_addr", 64'(ib_addr), 64'(e_wr_i ? e_addr : 0));
      chk("ib_data", ib_data, e_wr_i ? e_data : '0);
    end
    if (!wb_cenb && !wb_wenb) begin
      wmem[wb_addr] = wb_data; wr_cnt++; last_waddr = int'(wb_addr);
    end
    if (!ib_cenb && !ib_wenb) begin
      imem[ib_addr] = ib_data; wr_cnt++;
    end
    if (err) err_seen++;
  end

  task automatic pulse_go(input int wl, input int il);
    cfg_w = (WAW + 1)'(wl);
    cfg_i = (IAW + 1)'(il);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Offers n words; seq selects base+k data, otherwise random data and stray go pulses.
  task automatic stream(input int n, input int vpct, input bit seq, input logic [DW-1:0] base);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 5000) begin
      bit v, rdy;
      v = ($urandom_range(99) < vpct);
      s_valid = v;
      s_data = seq ? base + DW'(k) : DW'($urandom);
      go = (!seq && $urandom_range(9) == 0);
      rdy = s_ready;
      @(negedge clk);
      if (v && rdy) k++;
      budget++;
    end
    s_valid = 1'b0;
    go = 1'b0;
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d words expected %0d", k, n);
    end
  endtask

  // Acts as the controller: stale done high, then low for some cycles, then high.
  task automatic finish_run(input int stale, input int low);
    int b = 0;
    while (!start && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (!start) begin errors++; $display("FAIL start_timeout: start_o 0 expected 1"); end
    done = 1'b1;
    repeat (stale) @(negedge clk);
    done = 1'b0;
    repeat (low) @(negedge clk);
    done = 1'b1;
    b = 0;
    while (busy && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (busy) begin errors++; $display("FAIL idle_timeout: busy_o 1 expected 0"); end
  endtask

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_wb_cenb", wb_cenb, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_lact", load_active, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic load, stale done from "previous run" then one low cycle.
    w0 = wr_cnt;
    pulse_go(4, 6);
    stream(10, 100, 1'b1, 32'hA000_0000);
    finish_run(3, 1);
    chk("basic_writes", 64'(wr_cnt - w0), 64'd10);
    chk("basic_w0", wmem[0], 32'hA000_0000);
    chk("basic_w3", wmem[3], 32'hA000_0003);
    chk("basic_i0", imem[0], 32'hA000_0004);
    chk("basic_i5", imem[5], 32'hA000_0009);

    // Valid pattern 1,0,0,1 during LOAD_W.
    pulse_go(4, 2);
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      s_valid = (i == 0 || i == 3);
      s_data = 32'hC000_0000 + DW'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("stall_writes", 64'(wr_cnt - w0), 64'd2);
    chk("stall_w0", wmem[0], 32'hC000_0000);
    chk("stall_w1", wmem[1], 32'hC000_0003);
    stream(4, 100, 1'b1, 32'hC100_0000);
    finish_run(0, 2);
    chk("stall_w2", wmem[2], 32'hC100_0000);

    // Illegal configurations.
    w0 = wr_cnt;
    err_seen = 0;
    pulse_go(0, 4);
    repeat (2) @(negedge clk);
    pulse_go(4, I_SIZE + 1);
    repeat (2) @(negedge clk);
    chk("illegal_err_pulses", 64'(err_seen), 64'd2);
    chk("illegal_writes", 64'(wr_cnt - w0), 64'd0);
    chk("illegal_busy", busy, 1'b0);

    // Full-depth weight buffer, single input word.
    pulse_go(W_SIZE, 1);
    stream(W_SIZE + 1, 100, 1'b1, 32'hB000_0000);
    finish_run(1, 1);
    chk("bound_last_waddr", 64'(last_waddr), 64'(W_SIZE - 1));
    chk("bound_w255", wmem[W_SIZE-1], 32'hB000_00FF);
    chk("bound_i0", imem[0], 32'hB000_0100);

    // Reset after 3 of 4 weight words, then restart from address 0.
    pulse_go(4, 2);
    stream(3, 100, 1'b1, 32'hD000_0000);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", s_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_wb_cenb", wb_cenb, 1'b1);
    rst = 1'b0;
    w0 = wr_cnt;
    pulse_go(4, 2);
    stream(6, 100, 1'b1, 32'hE000_0000);
    finish_run(2, 1);
    chk("restart_writes", 64'(wr_cnt - w0), 64'd6);
    chk("restart_w0", wmem[0], 32'hE000_0000);
    chk("restart_i1", imem[1], 32'hE000_0005);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      pulse_go($urandom_range(1, 20), $urandom_range(1, 20));
      stream(int'(cfg_w) + int'(cfg_i), $urandom_range(30, 100), 1'b0, '0);
      finish_run($urandom_range(0, 3), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
